// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// event width, event buffer depth and the active-low column drive patterns.
package keypad_pkg;

  localparam int KEY_W      = 4;
  localparam int FIFO_DEPTH = 4;

  localparam logic [3:0] COL_0    = 4'b1110;
  localparam logic [3:0] COL_1    = 4'b1101;
  localparam logic [3:0] COL_2    = 4'b1011;
  localparam logic [3:0] COL_3    = 4'b0111;
  localparam logic [3:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    return COL_0;
      2'd1:    return COL_1;
      2'd2:    return COL_2;
      default: return COL_3;
    endcase
  endfunction

  // True when exactly one row is pulled low; anything else is idle or ghosting.
  function automatic logic single_low(input logic [3:0] r);
    case (r)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] r);
    case (r)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Key event buffer: push/full on the write side, valid/ready on the read side.
// DEPTH 1 is a plain holding register; larger depths are a circular buffer.
module keypad_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  logic pop;
  logic wr_en;

  assign pop   = valid && ready;
  assign wr_en = push && (!full || pop);

  if (DEPTH == 1) begin : g_hold
    logic [W-1:0] hold_q;
    logic         hold_v;

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_v <= 1'b0;
        hold_q <= '0;
      end else if (wr_en) begin
        hold_v <= 1'b1;
        hold_q <= push_data;
      end else if (pop) begin
        hold_v <= 1'b0;
      end
    end

    assign full  = hold_v;
    assign valid = hold_v;
    assign data  = hold_v ? hold_q : '0;
  end else begin : g_ring
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // NOTE: storage is deliberately not reset; the read port is masked to 0
    // while empty, so stale contents can never reach the outputs.
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
        if (pop)   rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
        case ({wr_en, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    assign full  = (count == CNT_FULL);
    assign valid = (count != '0);
    assign data  = valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with debounce, ghost rejection and a key event
// buffer. Define KEYPAD_FIFO_EN for a 4-entry event FIFO; default is depth 1.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held,
  output logic             overflow,
  input  logic             ovf_clr
);

`ifdef KEYPAD_FIFO_EN
  localparam int EVT_DEPTH = FIFO_DEPTH;
`else
  localparam int EVT_DEPTH = 1;
`endif

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);

  state_t          state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      armed_q, armed_d;
  logic [3:0]      row_m, row_s;
  logic            push, full, drop;
  logic [KEY_W-1:0] evt_code;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m <= ROW_IDLE;
      row_s <= ROW_IDLE;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      pat_q     <= ROW_IDLE;
      armed_q   <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      armed_q   <= armed_d;
    end
  end

  // A column is armed once it has been seen idle; keys already down at reset
  // release stay invisible until they lift and are pressed again.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    col_idx_d = col_idx_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    armed_d   = armed_q;
    push      = 1'b0;

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_s == ROW_IDLE) armed_d[col_idx_q] = 1'b1;
          if (single_low(row_s) && armed_q[col_idx_q]) begin
            pat_d   = row_s;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s == pat_q) begin
          if (cnt_q == CNT_LAST) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d     = '0;
          dwell_d   = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end
      PRESSED: begin
        if (row_s == ROW_IDLE) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (row_s == ROW_IDLE) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign evt_code = {col_idx_q, low_idx(pat_q)};
  assign drop     = push && full && !(key_valid && key_ready);

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  keypad_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .W     (KEY_W)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (evt_code),
    .full      (full),
    .valid     (key_valid),
    .ready     (key_ready),
    .data      (key_code)
  );

  assign col      = col_drive(col_idx_q);
  assign key_held = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven (dwell), minimum 4.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 20000: consecutive stable cycles required for press and for release, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port row, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col, output, 4 bits: column drive, active-low one-hot.
REQ-007 SHALL have port key_valid, output, 1 bit: key event available.
REQ-008 SHALL have port key_ready, input, 1 bit: consumer accepts the event.
REQ-009 SHALL have port key_code, output, 4 bits: event code = col_idx*4 + row_idx.
REQ-010 SHALL have port key_held, output, 1 bit: a debounced key is currently down.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-012 SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-013 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value (row_s).
REQ-014 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-015 In SCAN, SHALL rotate col through 1110, 1101, 1011, 0111, 1110, advancing every SCAN_DIV cycles.
REQ-016 On the last dwell cycle in SCAN, if row_s has exactly one low bit, SHALL latch col_idx and row_idx, freeze col, and go to DEBOUNCE.
REQ-017 In SCAN, row_s of 1111 or with two or more low bits SHALL be ignored (ghosting rejection); scanning continues.
REQ-018 In DEBOUNCE, SHALL count cycles where row_s equals the latched pattern; any mismatch returns to SCAN at the next column with the counter cleared.
REQ-019 When the count reaches DEBOUNCE_CYC, SHALL push the event {col_idx, row_idx} and go to PRESSED; exactly one event per press.
REQ-020 In PRESSED, key_held SHALL be 1; row_s == 1111 SHALL go to RELEASE with the counter cleared.
REQ-021 In RELEASE, SHALL count consecutive row_s == 1111 cycles; any low bit returns to PRESSED; reaching DEBOUNCE_CYC SHALL return to SCAN at the next column.
REQ-022 key_held SHALL be 1 in PRESSED and RELEASE, 0 otherwise.
REQ-023 Handshake: an event transfers on a cycle with key_valid && key_ready; while key_valid && !key_ready, key_code SHALL stay stable.
REQ-024 A push when the buffer is full and not popped in the same cycle SHALL drop the event and set overflow.
REQ-025 A push and a pop in the same cycle SHALL both take effect, including when the buffer is full.
REQ-026 If ovf_clr and a drop occur in the same cycle, overflow SHALL be 1 (set wins).
REQ-027 Counters SHALL be $clog2-sized from the parameters; the dwell counter wraps from SCAN_DIV-1 to 0.

Reset
REQ-028 On rst, outputs SHALL be: col=1110, key_valid=0, key_code=0, key_held=0, overflow=0.
REQ-029 On rst, internal state SHALL be: state=SCAN, column index 0, all counters 0, synchronizer 1111, buffer empty.
REQ-030 rst asserted mid-press or mid-handshake SHALL discard all pending events; no event is emitted for a key already held at reset release until the key is released and pressed again through the normal debounce path.

Configuration
REQ-031 With KEYPAD_FIFO_EN defined, the event buffer SHALL be a 4-entry FIFO, first in first out.
REQ-032 Without KEYPAD_FIFO_EN, the buffer SHALL be a single holding register; REQ-024 and REQ-025 apply with depth 1.

Structure
REQ-033 Package keypad_pkg SHALL hold the state enum, KEY_W=4, FIFO_DEPTH=4, and the column one-hot constants.
REQ-034 The event buffer SHALL be sub-module keypad_evt_fifo (depth from the package or 1, valid/ready pop, push/full).

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8)
REQ-035 Reset then idle rows 1111 SHALL give col sequence 1110 x4, 1101 x4, 1011 x4, 0111 x4, repeating, with key_valid=0.
REQ-036 row=1101 held while col=1011 (col_idx 2, row_idx 1) with key_ready=1 SHALL give one key_valid pulse with key_code=9, col frozen at 1011, and key_held=1 until 8 released cycles.
REQ-037 row=1110 bouncing (5 cycles low, 1 high) then stable SHALL give no event until 8 stable cycles, then exactly one event.
REQ-038 row=1100 (two rows low) SHALL give no event and no change to the scan cadence.
REQ-039 With key_ready=0: presses 0, 1, 2, 3, 4 SHALL give, with FIFO, codes 0..3 retained and overflow=1 on the fifth; without FIFO, code 0 retained and overflow=1 on the second. ovf_clr SHALL then clear overflow.
REQ-040 rst pulsed during DEBOUNCE and again with key_valid=1 SHALL give the REQ-028/029 values on the next cycle and no stale event.
